// File: rtl/reg_file_lt.sv
// reg_file_lt: parametrised register file with constant regs 0/1, two
// bypassed combinational read ports, ALU and load-return write ports, and a
// single-outstanding-load tracker that flags read-after-load hazards.
module reg_file_lt #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned DED_IDX = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_dst,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic [DW-1:0] ded_out,
    output logic          ld_busy,
    output logic          hazA,
    output logic          hazB
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW-1:0] DED_A = AW'(DED_IDX);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] pend_dst;
    logic          cancel;
    logic [DW-1:0] mem [DEPTH];

    logic          ld_we;
    logic          alu_we;

    // Effective write enables: cancelled or constant-target loads write
    // nothing; a load return beats an ALU write to the same register.
    always_comb begin
        ld_we  = 1'b0;
        alu_we = 1'b0;
        ld_we  = (state == PENDING) && ld_valid && !cancel && (pend_dst > ONE_A);
        alu_we = wr_en && (wr_addr > ONE_A) && !(ld_we && (wr_addr == pend_dst));
    end

    // Register storage; entries 0 and 1 are never written and never read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ld_we) begin
                mem[pend_dst] <= ld_data;
            end
            if (alu_we) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Load tracker: holds the pending destination and whether a younger ALU
    // write has made the returning data stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend_dst <= '0;
            cancel   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        state    <= PENDING;
                        pend_dst <= ld_dst;
                        cancel   <= 1'b0;
                    end
                end
                PENDING: begin
                    if (ld_valid) begin
                        if (ld_req) begin
                            state    <= PENDING;
                            pend_dst <= ld_dst;
                        end else begin
                            state <= IDLE;
                        end
                        cancel <= 1'b0;
                    end else if (wr_en && (wr_addr == pend_dst)) begin
                        cancel <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read mux: constant, then load bypass, then ALU bypass, then storage.
    function automatic logic [DW-1:0] rd_mux(
        input logic [AW-1:0] a,
        input logic [DW-1:0] stored,
        input logic          lwe,
        input logic [AW-1:0] ldst,
        input logic [DW-1:0] ldat,
        input logic          awe,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdat
    );
        logic [DW-1:0] r;
        r = stored;
        if (a <= ONE_A) begin
            r = DW'(a);
        end else if (lwe && (a == ldst)) begin
            r = ldat;
        end else if (awe && (a == waddr)) begin
            r = wdat;
        end
        return r;
    endfunction

    // Combinational read ports and hazard flags.
    always_comb begin
        datA_out = rd_mux(rd_addrA, mem[rd_addrA], ld_we, pend_dst, ld_data,
                          alu_we, wr_addr, wr_data);
        datB_out = rd_mux(rd_addrB, mem[rd_addrB], ld_we, pend_dst, ld_data,
                          alu_we, wr_addr, wr_data);
        hazA = (state == PENDING) && (rd_addrA == pend_dst) && (rd_addrA > ONE_A) && !ld_valid;
        hazB = (state == PENDING) && (rd_addrB == pend_dst) && (rd_addrB > ONE_A) && !ld_valid;
    end

    assign ded_out = mem[DED_A];
    assign ld_busy = (state == PENDING);

endmodule

// File: tb/tb_reg_file_lt.sv
// tb_reg_file_lt: directed vector table, async-reset sequence, then random
// traffic against a transaction-level model of the register file.
module tb_reg_file_lt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       ld_req;
    logic [2:0] ld_dst;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic [2:0] rd_addrA;
    logic [2:0] rd_addrB;
    logic [7:0] datA_out;
    logic [7:0] datB_out;
    logic [7:0] ded_out;
    logic       ld_busy;
    logic       hazA;
    logic       hazB;

    int errors = 0;
    int checks = 0;

    reg_file_lt #(.DW(8), .AW(3), .DED_IDX(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_req(ld_req), .ld_dst(ld_dst), .ld_valid(ld_valid), .ld_data(ld_data),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(datA_out), .datB_out(datB_out), .ded_out(ded_out),
        .ld_busy(ld_busy), .hazA(hazA), .hazB(hazB)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       we;
        bit [2:0] wa;
        bit [7:0] wd;
        bit       lr;
        bit [2:0] ldst;
        bit       lv;
        bit [7:0] lq;
        bit [2:0] ra;
        bit [2:0] rb;
        bit [7:0] ea;
        bit [7:0] eb;
        bit [7:0] ed;
        bit       ebusy;
        bit       eha;
        bit       ehb;
    } vec_t;

    vec_t vecs[$];

    // Outstanding load as seen by the issuer: destination and whether the data
    // will still be written when it returns.
    typedef struct {
        int dst;
        bit live;
    } load_t;

    int    m_regs[8];
    load_t m_out[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(
        input bit we, input bit [2:0] wa, input bit [7:0] wd,
        input bit lr, input bit [2:0] ldst, input bit lv, input bit [7:0] lq,
        input bit [2:0] ra, input bit [2:0] rb,
        input bit [7:0] ea, input bit [7:0] eb, input bit [7:0] ed,
        input bit ebusy, input bit eha, input bit ehb);
        vec_t v;
        v = '{we, wa, wd, lr, ldst, lv, lq, ra, rb, ea, eb, ed, ebusy, eha, ehb};
        return v;
    endfunction

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        ld_req = 0; ld_dst = 0; ld_valid = 0; ld_data = 0;
        rd_addrA = 0; rd_addrB = 0;
    endtask

    // Model's read value for address a given the current input pins.
    function automatic int m_read(input int a);
        if (a < 2) return a;
        if (m_out.size() != 0 && ld_valid && m_out[0].live && m_out[0].dst == a)
            return ld_data;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit m_haz(input int a);
        return m_out.size() != 0 && !ld_valid && a > 1 && m_out[0].dst == a;
    endfunction

    // Retire the clock edge in the model.
    task automatic m_edge();
        bit ld_done;
        int ld_to;
        ld_done = 0;
        ld_to   = -1;
        if (m_out.size() != 0 && ld_valid) begin
            if (m_out[0].live && m_out[0].dst > 1) begin
                ld_done = 1;
                ld_to   = m_out[0].dst;
            end
            void'(m_out.pop_front());
        end else if (m_out.size() != 0 && wr_en && wr_addr == m_out[0].dst) begin
            m_out[0].live = 0;
        end
        if (ld_done) m_regs[ld_to] = ld_data;
        if (wr_en && wr_addr > 1 && !(ld_done && ld_to == wr_addr)) m_regs[wr_addr] = wr_data;
        if (ld_req && m_out.size() == 0) m_out.push_back('{dst: ld_dst, live: 1'b1});
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        //       we wa wd     lr ld lv lq     ra rb  ea     eb     ed     by hA hB
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 2, 7, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(1, 5, 8'hA5, 0, 0, 0, 8'h00, 5, 5, 8'hA5, 8'hA5, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 8'hFF, 0, 0, 0, 8'h00, 5, 0, 8'hA5, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 3, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 1, 2, 0, 8'h00, 5, 2, 8'hA5, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 2, 8'hA5, 8'h00, 8'h00, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 2, 8'hA5, 8'h00, 8'h00, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 2, 8'hA5, 8'h00, 8'h00, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 1, 8'h3C, 5, 2, 8'hA5, 8'h3C, 8'h00, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 2, 8'hA5, 8'h3C, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 1, 3, 0, 8'h00, 3, 4, 8'h00, 8'h00, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 1, 4, 1, 8'h11, 3, 4, 8'h11, 8'h00, 8'h3C, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 3, 4, 8'h11, 8'h00, 8'h3C, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 1, 8'h22, 3, 4, 8'h11, 8'h22, 8'h3C, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 4, 3, 8'h22, 8'h11, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 1, 6, 0, 8'h00, 6, 6, 8'h00, 8'h00, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(1, 6, 8'h77, 0, 0, 0, 8'h00, 6, 6, 8'h77, 8'h77, 8'h3C, 1, 1, 1));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 1, 8'h99, 6, 6, 8'h77, 8'h77, 8'h3C, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 6, 6, 8'h77, 8'h77, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 1, 7, 0, 8'h00, 7, 7, 8'h00, 8'h00, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(1, 7, 8'hC3, 0, 0, 1, 8'h5A, 7, 7, 8'h5A, 8'h5A, 8'h3C, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 7, 7, 8'h5A, 8'h5A, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 1, 8'hEE, 0, 1, 8'h00, 8'h01, 8'h3C, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 1, 8'h44, 5, 2, 8'hA5, 8'h3C, 8'h3C, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 2, 8'hA5, 8'h3C, 8'h3C, 0, 0, 0));

        // Directed table.
        foreach (vecs[i]) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            ld_req = vecs[i].lr; ld_dst = vecs[i].ldst;
            ld_valid = vecs[i].lv; ld_data = vecs[i].lq;
            rd_addrA = vecs[i].ra; rd_addrB = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d datA", i), int'(datA_out), int'(vecs[i].ea));
            chk($sformatf("vec%0d datB", i), int'(datB_out), int'(vecs[i].eb));
            chk($sformatf("vec%0d ded", i), int'(ded_out), int'(vecs[i].ed));
            chk($sformatf("vec%0d busy", i), int'(ld_busy), int'(vecs[i].ebusy));
            chk($sformatf("vec%0d hazA", i), int'(hazA), int'(vecs[i].eha));
            chk($sformatf("vec%0d hazB", i), int'(hazB), int'(vecs[i].ehb));
            @(posedge clk);
            @(negedge clk);
        end

        // Async reset while a load to reg6 (holding 0x77) is pending.
        idle_inputs();
        ld_req = 1; ld_dst = 6;
        rd_addrA = 6; rd_addrB = 2;
        @(posedge clk);
        #3;
        ld_req = 0;
        chk("pre_rst busy", int'(ld_busy), 1);
        chk("pre_rst reg6", int'(datA_out), 8'h77);
        rst_n = 0;
        #1;
        chk("rst busy", int'(ld_busy), 0);
        chk("rst reg6", int'(datA_out), 0);
        chk("rst ded", int'(ded_out), 0);
        chk("rst hazA", int'(hazA), 0);
        @(negedge clk);
        rst_n = 1;
        ld_valid = 1; ld_data = 8'hAB;
        #1;
        chk("post_rst ldv datA", int'(datA_out), 0);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 0;
        for (int a = 0; a < 8; a++) begin
            rd_addrA = 3'(a);
            rd_addrB = 3'(7 - a);
            #1;
            chk($sformatf("post_rst rdA%0d", a), int'(datA_out), (a == 1) ? 1 : 0);
            chk($sformatf("post_rst rdB%0d", 7 - a), int'(datB_out), (a == 6) ? 1 : 0);
        end
        chk("post_rst busy", int'(ld_busy), 0);
        chk("post_rst ded", int'(ded_out), 0);

        // Random traffic against the model, starting from the reset state.
        foreach (m_regs[i]) m_regs[i] = 0;
        m_out.delete();
        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            ld_valid = (m_out.size() != 0) ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 7) == 0);
            ld_data  = 8'($urandom);
            ld_req   = (m_out.size() == 0 || ld_valid) ? ($urandom_range(0, 2) == 0) : 1'b0;
            ld_dst   = 3'($urandom_range(0, 7));
            rd_addrA = 3'($urandom_range(0, 7));
            rd_addrB = ($urandom_range(0, 3) == 0 && m_out.size() != 0)
                       ? 3'(m_out[0].dst) : 3'($urandom_range(0, 7));
            #1;
            chk("rnd datA", int'(datA_out), m_read(rd_addrA));
            chk("rnd datB", int'(datB_out), m_read(rd_addrB));
            chk("rnd ded", int'(ded_out), m_regs[2]);
            chk("rnd busy", int'(ld_busy), int'(m_out.size() != 0));
            chk("rnd hazA", int'(hazA), int'(m_haz(rd_addrA)));
            chk("rnd hazB", int'(hazB), int'(m_haz(rd_addrB)));
            @(posedge clk);
            m_edge();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
